addsub_mul_sequencer: RTL

ADDSUB_MUL_SEQUENCER -- requirements
Module: addsub_mul_sequencer

---
 rtl/Sixteen_b_full_adder.sv | 38 +++
 rtl/addsub_mul_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/Sixteen_b_full_adder.sv
// Sixteen_b_full_adder
//   16-bit ripple-carry adder/subtractor built from single-bit full-adder
//   cells. With i_x=0 it computes i_a + i_b; with i_x=1 it computes
//   i_a + ~i_b + 1 = i_a - i_b. In that case o_c_out=1 means no borrow.
//
// Ports
//   i_a     [15:0]  first operand
//   i_b     [15:0]  second operand (inverted internally when i_x=1)
//   i_x             0 = add, 1 = subtract
//   o_s     [15:0]  sum / difference
//   o_c_out         carry out of bit 15
module Sixteen_b_full_adder (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_x,
  output logic [15:0] o_s,
  output logic        o_c_out
);

  logic [16:0] w_c;
  logic [15:0] w_b_eff;

  // In subtract mode the carry-in supplies the +1 of the two's complement.
  assign w_c[0] = i_x;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_bit
      assign w_b_eff[gi] = i_b[gi] ^ i_x;
      assign o_s[gi]     = i_a[gi] ^ w_b_eff[gi] ^ w_c[gi];
      assign w_c[gi+1]   = (i_a[gi] & w_b_eff[gi]) |
                           (w_c[gi] & (i_a[gi] ^ w_b_eff[gi]));
    end
  endgenerate

  assign o_c_out = w_c[16];

endmodule

// File: rtl/addsub_mul_sequencer.sv
// addsub_mul_sequencer
//   Small arithmetic sequencer: unsigned 8-bit ADD and SUB in one EXEC
//   cycle, 8x8 unsigned MUL as an 8-cycle shift-and-add loop. All
//   add/subtract work goes through a single shared 16-bit adder.
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous active-high reset
//   start          operation request, sampled only in IDLE
//   op     [1:0]   00 ADD, 01 SUB (a-b), 10 MUL, 11 reserved (err)
//   a, b   [7:0]   unsigned operands
//   busy           high in EXEC and RUN
//   done           one-cycle completion pulse (the DONE state)
//   result [15:0]  registered result, held until the next completion
//   carry          adder carry out for ADD/SUB (SUB: 1 = no borrow), else 0
//   err            high together with done for the reserved opcode
module addsub_mul_sequencer #(
  parameter int OP_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              busy,
  output logic              done,
  output logic [2*OP_W-1:0] result,
  output logic              carry,
  output logic              err
);

  localparam int RES_W = 2 * OP_W;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [2:0] LAST_BIT = 3'(OP_W - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [OP_W-1:0]   r_a;
  logic [OP_W-1:0]   r_b;
  logic [1:0]        r_op;
  logic [RES_W-1:0]  r_acc;
  logic [2:0]        r_i;
  logic [RES_W-1:0]  r_result;
  logic              r_carry;
  logic              r_done;
  logic              r_err;
  logic              r_busy;

  logic [RES_W-1:0]  w_a_ext;
  logic [RES_W-1:0]  w_b_ext;
  logic [RES_W-1:0]  w_add_a;
  logic [RES_W-1:0]  w_add_b;
  logic              w_add_x;
  logic [RES_W-1:0]  w_sum;
  logic              w_cout;

  assign w_a_ext = {{(RES_W-OP_W){1'b0}}, r_a};
  assign w_b_ext = {{(RES_W-OP_W){1'b0}}, r_b};

  // Adder operand steering. Outside EXEC/RUN the adder sees zeros; its
  // output is only consumed in those two states.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    w_add_x = 1'b0;
    case (r_state)
      S_EXEC: begin
        w_add_a = w_a_ext;
        w_add_b = w_b_ext;
        w_add_x = (r_op == OP_SUB);
      end
      S_RUN: begin
        // Partial product for bit i: (a << i) when b[i] is set, else 0.
        w_add_a = r_acc;
        if (r_b[r_i]) begin
          w_add_b = w_a_ext << r_i;
        end
      end
      default: begin
      end
    endcase
  end

  Sixteen_b_full_adder u_adder (
    .i_a     (w_add_a),
    .i_b     (w_add_b),
    .i_x     (w_add_x),
    .o_s     (w_sum),
    .o_c_out (w_cout)
  );

  // Single FSM process. busy/done/err are registered alongside the state
  // transition so they line up exactly with EXEC/RUN and DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_acc    <= '0;
      r_i      <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_op  <= op;
            r_acc <= '0;
            r_i   <= '0;
            if (op == OP_ADD || op == OP_SUB) begin
              r_state <= S_EXEC;
              r_busy  <= 1'b1;
            end else if (op == OP_MUL) begin
              r_state <= S_RUN;
              r_busy  <= 1'b1;
            end else begin
              // Reserved opcode: report straight away, result cleared.
              r_state  <= S_DONE;
              r_done   <= 1'b1;
              r_err    <= 1'b1;
              r_result <= '0;
              r_carry  <= 1'b0;
            end
          end
        end
        S_EXEC: begin
          r_result <= w_sum;
          r_carry  <= w_cout;
          r_state  <= S_DONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b1;
        end
        S_RUN: begin
          r_acc <= w_sum;
          r_i   <= r_i + 3'd1;
          if (r_i == LAST_BIT) begin
            // Max product 0xFE01 fits, so the adder never carries out here.
            r_result <= w_sum;
            r_carry  <= 1'b0;
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;
  assign carry  = r_carry;
  assign err    = r_err;

endmodule
